// File: rtl/vga_fill_engine.sv
// Rectangle-fill and single-pixel write engine feeding the VGA image-RAM write port.
// Optional clipping to the visible area is enabled by defining VGA_FILL_CLIP_EN.
module vga_fill_engine #(
  parameter int unsigned COL_BITS = 11,
  parameter int unsigned ROW_BITS = 3,
  parameter int unsigned COLS     = 640,
  parameter int unsigned ROWS     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wEn,
  input  logic [1:0]  addr,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        done,
  output logic [31:0] image_word
);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e              state;
  logic [ROW_BITS-1:0] orow;
  logic [COL_BITS-1:0] ocol;
  logic [COL_BITS:0]   w, c;
  logic [ROW_BITS:0]   h, r;
  logic [7:0]          colour;
  logic                err;

  logic wr_origin, wr_size, wr_ctrl, wr_pixel;
  logic ctrl_start, ctrl_abort, err_clr;

  assign wr_origin  = wEn && (addr == 2'd0);
  assign wr_size    = wEn && (addr == 2'd1);
  assign wr_ctrl    = wEn && (addr == 2'd2);
  assign wr_pixel   = wEn && (addr == 2'd3);
  assign ctrl_start = wr_ctrl && dataIn[8];
  assign ctrl_abort = wr_ctrl && dataIn[9];
  assign err_clr    = wr_ctrl && dataIn[10];

  assign dataOut = {30'b0, err, state == StFill};

  logic                last_col, last_pix;
  logic [COL_BITS:0]   nxt_c, pos_c, col_sum;
  logic [ROW_BITS:0]   nxt_r, pos_r, row_sum;
  logic [7:0]          pix_colour;
  logic [31:0]         fill_word, pixel_word;

  assign last_col = (c == w - 1'b1);
  assign last_pix = last_col && (r == h - 1'b1);
  assign nxt_c    = last_col ? '0 : c + 1'b1;
  assign nxt_r    = last_col ? r + 1'b1 : r;

  // Packed pixel format: idx and addr share dataIn[14], so the image address bit 14 follows it.
  assign pixel_word = {8'h00, 1'b1, dataIn[21:14], dataIn[14:0]};

  // Word for the next fill position; on a start it is the origin itself with the new colour.
  always_comb begin
    pos_c      = '0;
    pos_r      = '0;
    pix_colour = dataIn[7:0];
    if (state == StFill) begin
      pos_c      = nxt_c;
      pos_r      = nxt_r;
      pix_colour = colour;
    end
    col_sum   = {1'b0, ocol} + pos_c;
    row_sum   = {1'b0, orow} + pos_r;
    fill_word = {8'h00, 1'b1, pix_colour, 1'b0, row_sum[ROW_BITS-1:0], col_sum[COL_BITS-1:0]};
`ifdef VGA_FILL_CLIP_EN
    if ((32'(col_sum) >= COLS) || (32'(row_sum) >= ROWS)) begin
      fill_word = '0;
    end
`endif
  end

`ifndef VGA_FILL_CLIP_EN
  logic unused_clip;
  assign unused_clip = ^{col_sum[COL_BITS], row_sum[ROW_BITS], 32'(COLS), 32'(ROWS)};
`endif

  logic unused_data;
  assign unused_data = ^dataIn[31:22];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StIdle;
      orow       <= '0;
      ocol       <= '0;
      w          <= '0;
      h          <= '0;
      c          <= '0;
      r          <= '0;
      colour     <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
      image_word <= '0;
    end else begin
      image_word <= '0;
      done       <= 1'b0;
      case (state)
        StFill: begin
          if (wr_origin || wr_size || wr_pixel || (ctrl_start && !ctrl_abort)) begin
            err <= 1'b1;
          end
          if (ctrl_abort || last_pix) begin
            state <= StDone;
            done  <= 1'b1;
          end else begin
            c          <= nxt_c;
            r          <= nxt_r;
            image_word <= fill_word;
          end
        end
        default: begin
          // The one-cycle DONE state accepts CPU writes exactly like IDLE.
          state <= StIdle;
          if (wr_origin) begin
            orow <= dataIn[16 +: ROW_BITS];
            ocol <= dataIn[COL_BITS-1:0];
          end
          if (wr_size) begin
            w <= dataIn[COL_BITS:0];
            h <= dataIn[16 +: ROW_BITS+1];
          end
          if (wr_pixel) begin
            image_word <= pixel_word;
          end else if (ctrl_start) begin
            colour <= dataIn[7:0];
            c      <= '0;
            r      <= '0;
            if ((w != '0) && (h != '0)) begin
              state      <= StFill;
              image_word <= fill_word;
            end
          end
        end
      endcase
      if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule
